toy_dmem_resp: RTL and testbench
================================

# toy_dmem_resp

Data-memory responder for the RISC_TOY core's data port: the memory end of the DREQ/DRW/DADDR/DWDATA/DRDATA interface. It accepts one request per cycle, returns registered read data one cycle later, and posts writes into a small write buffer. The buffer drains into a single-port word array during idle cycles, and reads forward from pending buffered writes. It sits beside the core at top level, in place of the bench's behavioural data memory.

## Interface
- AW, 10: word-index bits used from DADDR; array holds 2**AW 32-bit words.
- WB_DEPTH, 4: write-buffer entries; power of two, at least 2.
- CLK  input  1  sole clock; rising edge.
- RST  input  1  asynchronous, active-high reset.
- DREQ  input  1  request valid this cycle.
- DRW  input  1  1 = write, 0 = read; sampled only when DREQ=1.
- DADDR  input  30  word address; only DADDR[AW-1:0] used; upper bits ignored (aliasing).
- DWDATA  input  32  write data; sampled on write cycles.
- DRDATA  output  32  registered read data.
- WB_CNT  output  $clog2(WB_DEPTH)+1  current buffer occupancy (debug/verification).

## Operation
- Reset: buffer emptied (WB_CNT=0, pointers 0); DRDATA=0. Array contents are not reset. Pending buffered writes are discarded on reset, including mid-drain.
- Each cycle is one of three kinds:
  - Idle cycle (DREQ=0): if WB_CNT>0, the oldest entry is written to the array and dequeued.
  - Read cycle (DREQ=1, DRW=0): the array port serves the read; no drain.
    - DRDATA <= data of the youngest buffer entry whose address equals DADDR[AW-1:0], if any; otherwise array[DADDR[AW-1:0]].
  - Write cycle (DREQ=1, DRW=1): {DADDR[AW-1:0], DWDATA} is enqueued.
    - If WB_CNT==WB_DEPTH, the oldest entry is written to the array and dequeued in the same cycle, so the buffer never overflows and the count stays WB_DEPTH.
    - If WB_CNT<WB_DEPTH, there is no drain and the count increments.
- No coalescing: duplicate addresses may coexist. Drain order is strict FIFO, so the last write to an address reaches the array last.
- Forwarding compares all valid entries. The youngest match wins, with age taken from the write pointer, and must be correct across pointer wrap-around.
- DRDATA holds its value on idle and write cycles; it changes only on read cycles.
- There is no stall or ready signal. Every request is accepted in the cycle it is presented.

## Timing
- Read latency is 1 cycle. A read sampled at edge N has DRDATA valid after edge N, for the whole cycle N+1.
- Read-after-write is back-to-back: a write at edge N followed by a read of the same address at edge N+1 returns the new data after N+1 via forwarding.
- A drain write to the array completes at the edge of the idle or full-write cycle. A read in the following cycle sees it from the array.
- WB_CNT updates at the same edge as enqueue/dequeue.
- Reset is asynchronous assert. Deassertion is assumed synchronous to CLK, which is handled at top level.

## Structure
- Shared package toy_mem_pkg holds:
  - constants DRW_READ=1'b0 and DRW_WRITE=1'b1;
  - the write-buffer entry typedef {addr[AW-1:0], data[31:0]};
  - the default AW and WB_DEPTH.
- Sub-module toy_wbuf: circular FIFO with rd/wr pointers, count, and a combinational youngest-match lookup port (hit, data).
- The top contains the array, the cycle-kind decode, the drain control, and the DRDATA register.

## Test plan
- Reset: assert RST mid-stream with WB_CNT=3 → WB_CNT=0 and DRDATA=0 immediately. A later read of those addresses returns the pre-existing array contents, not the discarded writes.
- Forwarding: write addr 5 = 0xA5A5_0001, then read addr 5 the next cycle → DRDATA=0xA5A5_0001 one cycle later; WB_CNT=1.
- Youngest wins across wrap, with WB_DEPTH=4: write addr 7 = 1,2,3,4,5 on consecutive cycles (the fifth forces a drain of value 1), then read addr 7 → DRDATA=5 and WB_CNT=4.
- Drain: with WB_CNT=4 holding addrs 1..4 (data 0x11..0x44), hold DREQ=0 for 4 cycles → WB_CNT steps 3,2,1,0. Reads of addrs 1..4 then return 0x11..0x44 from the array.
- Aliasing and hold: write DADDR=0x400|3 = 0xDEAD with AW=10, then read addr 3 → 0xDEAD. An idle cycle or a write to addr 9 between reads leaves DRDATA at 0xDEAD.
- Random: 10k mixed read/write/idle cycles against a reference word-array model → every DRDATA matches and WB_CNT never exceeds WB_DEPTH.

Source files
------------

// File: rtl/toy_mem_pkg.sv
// Shared definitions for the RISC_TOY data-memory responder: DRW encoding,
// default geometry and the write-buffer entry layout.
package toy_mem_pkg;

  localparam int unsigned DEF_AW       = 10;
  localparam int unsigned DEF_WB_DEPTH = 4;

  localparam logic DRW_READ  = 1'b0;
  localparam logic DRW_WRITE = 1'b1;

  // Entry address field is DEF_AW wide; instances must keep AW <= DEF_AW.
  typedef struct packed {
    logic [DEF_AW-1:0] addr;
    logic [31:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/toy_wbuf.sv
// Circular write-buffer FIFO with a combinational youngest-match lookup used
// for read forwarding.
module toy_wbuf
  import toy_mem_pkg::*;
#(
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned DEPTH = DEF_WB_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic [$clog2(DEPTH):0]   cnt,
  input  logic [AW-1:0]            lookup_addr,
  output logic                     hit,
  output logic [31:0]              hit_data
);

  localparam int unsigned PW = $clog2(DEPTH);

  wb_entry_t      ent_q [DEPTH];
  wb_entry_t      ent_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW:0]    cnt_q, cnt_d;

  always_comb begin
    ent_d    = ent_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      ent_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign head = ent_q[rd_ptr_q];
  assign cnt  = cnt_q;

  // Walk back from the write pointer so the first valid match is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      logic [PW-1:0] idx;
      idx = wr_ptr_q - PW'(k);
      if (!hit && ((PW+1)'(k) <= cnt_q) && (ent_q[idx].addr[AW-1:0] == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = ent_q[idx].data;
      end
    end
  end

endmodule

// File: rtl/toy_dmem_resp.sv
// Data-memory responder: single-port word array, buffered writes drained on
// idle cycles, registered reads with forwarding from pending writes.
module toy_dmem_resp
  import toy_mem_pkg::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned WB_DEPTH = DEF_WB_DEPTH
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        DREQ,
  input  logic                        DRW,
  input  logic [29:0]                 DADDR,
  input  logic [31:0]                 DWDATA,
  output logic [31:0]                 DRDATA,
  output logic [$clog2(WB_DEPTH):0]   WB_CNT
);

  logic [31:0]   mem [2**AW];
  logic [AW-1:0] word_addr;
  logic          unused_addr;
  logic          is_rd, is_wr, wb_full, drain;
  wb_entry_t     push_entry, head;
  logic          hit;
  logic [31:0]   hit_data;
  logic [31:0]   drdata_q, drdata_d;

  assign word_addr   = DADDR[AW-1:0];
  assign unused_addr = ^DADDR[29:AW];

  assign is_rd   = DREQ && (DRW == DRW_READ);
  assign is_wr   = DREQ && (DRW == DRW_WRITE);
  assign wb_full = (WB_CNT == ($clog2(WB_DEPTH)+1)'(WB_DEPTH));
  // A full-buffer write retires the oldest entry so the push never overflows.
  assign drain   = (!DREQ && (WB_CNT != '0)) || (is_wr && wb_full);

  always_comb begin
    push_entry      = '0;
    push_entry.addr = $bits(push_entry.addr)'(word_addr);
    push_entry.data = DWDATA;
  end

  toy_wbuf #(
    .AW    (AW),
    .DEPTH (WB_DEPTH)
  ) u_wbuf (
    .clk         (CLK),
    .rst         (RST),
    .push        (is_wr),
    .push_entry  (push_entry),
    .pop         (drain),
    .head        (head),
    .cnt         (WB_CNT),
    .lookup_addr (word_addr),
    .hit         (hit),
    .hit_data    (hit_data)
  );

  always_ff @(posedge CLK) begin
    if (drain) begin
      mem[head.addr[AW-1:0]] <= head.data;
    end
  end

  always_comb begin
    drdata_d = drdata_q;
    if (is_rd) begin
      drdata_d = hit ? hit_data : mem[word_addr];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      drdata_q <= '0;
    end else begin
      drdata_q <= drdata_d;
    end
  end

  assign DRDATA = drdata_q;

endmodule

// File: tb/tb_toy_dmem_resp.sv
// Bench for toy_dmem_resp: directed vector table, reset corner case and a
// random stream checked against a FIFO-buffered reference memory.
module tb_toy_dmem_resp;

  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 4;

  logic        CLK, RST, DREQ, DRW;
  logic [29:0] DADDR;
  logic [31:0] DWDATA, DRDATA;
  logic [2:0]  WB_CNT;

  toy_dmem_resp #(.AW(AW), .WB_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR),
    .DWDATA(DWDATA), .DRDATA(DRDATA), .WB_CNT(WB_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct { logic [9:0] a; logic [31:0] d; } ent_t;
  typedef struct {
    bit req; bit rw; logic [29:0] addr; logic [31:0] wd;
    bit chk_rd; logic [31:0] rd; int cnt;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [1024];
  ent_t        ref_q [$];
  logic [31:0] exp_q [$];
  logic [31:0] ref_rd;
  vec_t        tbl [$];

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_1234 ^ (32'(i) << 16) ^ 32'(i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: update the model, push read expectations, drive, compare.
  task automatic step(input bit req, input bit rw, input logic [29:0] addr, input logic [31:0] wd);
    logic [9:0]  a;
    logic [31:0] v;
    ent_t        e;
    a = addr[9:0];
    if (!req) begin
      if (ref_q.size() > 0) begin e = ref_q.pop_front(); ref_mem[e.a] = e.d; end
    end else if (!rw) begin
      v = ref_mem[a];
      for (int i = ref_q.size() - 1; i >= 0; i--) begin
        if (ref_q[i].a == a) begin v = ref_q[i].d; break; end
      end
      exp_q.push_back(v);
      ref_rd = v;
    end else begin
      if (ref_q.size() == DEPTH) begin e = ref_q.pop_front(); ref_mem[e.a] = e.d; end
      e.a = a; e.d = wd;
      ref_q.push_back(e);
    end
    DREQ = req; DRW = rw; DADDR = addr; DWDATA = wd;
    @(posedge CLK); #1;
    if (req && !rw) check("drdata_read", DRDATA, exp_q.pop_front());
    else            check("drdata_hold", DRDATA, ref_rd);
    check("wb_cnt", 32'(WB_CNT), 32'(ref_q.size()));
  endtask

  function automatic void add(input bit req, input bit rw, input logic [29:0] addr,
                              input logic [31:0] wd, input bit chk_rd, input logic [31:0] rd, input int cnt);
    vec_t v;
    v.req = req; v.rw = rw; v.addr = addr; v.wd = wd; v.chk_rd = chk_rd; v.rd = rd; v.cnt = cnt;
    tbl.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [29:0] ra;
    int          op;
    RST = 1'b1; DREQ = 1'b0; DRW = 1'b0; DADDR = '0; DWDATA = '0;
    ref_rd = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_drdata", DRDATA, 32'h0);
    check("reset_wb_cnt", 32'(WB_CNT), 32'd0);
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < 1024; i++) begin
      step(1'b1, 1'b1, 30'(i), init_val(i));
      step(1'b0, 1'b0, '0, '0);
    end

    // Forwarding
    add(1, 1, 30'd5, 32'hA5A5_0001, 0, 0, 1);
    add(1, 0, 30'd5, 0, 1, 32'hA5A5_0001, 1);
    add(0, 0, 0, 0, 1, 32'hA5A5_0001, 0);
    // Youngest match across pointer wrap
    for (int v = 1; v <= 5; v++) add(1, 1, 30'd7, 32'(v), 0, 0, (v < 4) ? v : 4);
    add(1, 0, 30'd7, 0, 1, 32'd5, 4);
    for (int c = 3; c >= 0; c--) add(0, 0, 0, 0, 1, 32'd5, c);
    add(1, 0, 30'd7, 0, 1, 32'd5, 0);
    // Drain to array, then read back
    for (int k = 1; k <= 4; k++) add(1, 1, 30'(k), 32'(k * 32'h11), 0, 0, k);
    for (int c = 3; c >= 0; c--) add(0, 0, 0, 0, 0, 0, c);
    for (int k = 1; k <= 4; k++) add(1, 0, 30'(k), 0, 1, 32'(k * 32'h11), 0);
    // Aliasing and hold
    add(1, 1, 30'h403, 32'h0000_DEAD, 0, 0, 1);
    add(1, 0, 30'd3, 0, 1, 32'h0000_DEAD, 1);
    add(0, 0, 0, 0, 1, 32'h0000_DEAD, 0);
    add(1, 1, 30'd9, 32'h99, 1, 32'h0000_DEAD, 1);
    add(1, 0, 30'd3, 0, 1, 32'h0000_DEAD, 1);
    add(0, 0, 0, 0, 1, 32'h0000_DEAD, 0);

    foreach (tbl[i]) begin
      step(tbl[i].req, tbl[i].rw, tbl[i].addr, tbl[i].wd);
      if (tbl[i].chk_rd) check("tbl_drdata", DRDATA, tbl[i].rd);
      check("tbl_wb_cnt", 32'(WB_CNT), 32'(tbl[i].cnt));
    end

    // Reset mid-stream discards three pending writes
    step(1'b1, 1'b1, 30'd10, 32'h1111_0000);
    step(1'b1, 1'b1, 30'd11, 32'h2222_0000);
    step(1'b1, 1'b1, 30'd12, 32'h3333_0000);
    check("pre_reset_wb_cnt", 32'(WB_CNT), 32'd3);
    #2 RST = 1'b1;
    #1;
    check("async_reset_wb_cnt", 32'(WB_CNT), 32'd0);
    check("async_reset_drdata", DRDATA, 32'h0);
    ref_q.delete();
    ref_rd = '0;
    DREQ = 1'b0;
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    for (int k = 10; k <= 12; k++) begin
      step(1'b1, 1'b0, 30'(k), '0);
      check("post_reset_array", DRDATA, init_val(k));
    end

    // Random mix with narrow address range to exercise hits and aliasing
    for (int n = 0; n < 10000; n++) begin
      op = $urandom_range(0, 2);
      ra = 30'($urandom_range(0, 15));
      ra[29:28] = 2'($urandom_range(0, 3));
      ra[10]    = 1'($urandom_range(0, 1));
      step(op != 0, op == 2, ra, $urandom);
    end
    step(1'b0, 1'b0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
